mmio_pwm_led_ctrl: RTL and testbench
====================================

// Module: mmio_pwm_led_ctrl
// PURPOSE
//  Memory-mapped N-channel LED/RGB driver for the multicycle RISC-V core; replaces fixed led/red/green/blue nets.
//  Each channel has its own mode: off, on, PWM dim, or PWM blink.
//  Driven by datapath load/store bus; outputs go straight to board pins (polarity set by parameter).
// PARAMETERS
//  NUM_CH       4             number of output channels (1..16)
//  CNT_WIDTH    8             PWM counter/duty width; period = 2**CNT_WIDTH ticks
//  PRE_WIDTH    16            prescaler register width
//  BASE_ADDR    32'hFFFF_FF00 bus window base; decode addr[31:8]==BASE_ADDR[31:8]
//  ACTIVE_LOW   1             1: channel "on" drives pin 0
// PORTS
//  clk       in   1          system clock
//  reset     in   1          synchronous, active-high
//  addr      in   32         byte address; addr[1:0] ignored
//  wdata     in   32         write data
//  we        in   1          write strobe, one cycle
//  re        in   1          read strobe, one cycle
//  rdata     out  32         read data, valid cycle after re
//  ch_out    out  NUM_CH     pin drive per channel
// BEHAVIOUR
//  Register map (offset = addr[7:0]):
//   0x00 GCTRL  RW  bit0 global enable (gen)
//   0x04 PRESC  RW  [PRE_WIDTH-1:0]
//   0x08 COUNT  RO  [CNT_WIDTH-1:0] live pwm_cnt
//   0x10+4*i CHi RW  [CNT_WIDTH-1:0] duty, [17:16] mode; i<NUM_CH
//  Unmapped/RO writes ignored; unmapped reads return 0; unused bits read 0.
//  rdata registered: 1-cycle latency; we+re same cycle -> write applied, read returns pre-write value.
//  Prescaler: pre_cnt counts 0..PRESC, tick when pre_cnt==PRESC, then wraps to 0; PRESC=0 -> tick every cycle.
//  PRESC written mid-count: if pre_cnt>=new PRESC, next cycle ticks and wraps (compare is >=).
//  On tick: pwm_cnt+1, wrap 2**CNT_WIDTH-1 -> 0.
//  Wrap = tick while pwm_cnt is all-ones; at wrap: duty_shadow[i] <= CHi.duty, blink_ph toggles.
//  Duty writes take effect only at next wrap (glitch-free); mode writes take effect next cycle.
//  on[i]: mode 00 -> 0; 01 -> 1; 10 -> pwm_cnt<duty_shadow; 11 -> blink_ph & (pwm_cnt<duty_shadow).
//  duty 0 -> never on in PWM; duty all-ones -> on 255/256 at CNT_WIDTH=8. Use mode 01 for 100%.
//  ch_out[i] <= on[i] ^ ACTIVE_LOW, registered: reflects pwm_cnt/mode of previous cycle.
//  gen=0: pre_cnt, pwm_cnt, blink_ph held at 0; duty_shadow loads CHi.duty every cycle; all ch_out inactive.
//  gen 0->1: counting starts from 0 on the next cycle.
//  Reset (any time, incl. mid-period): all registers, counters, shadows, blink_ph = 0.
//   rdata = 0; ch_out = {NUM_CH{ACTIVE_LOW}} (inactive) the cycle after reset is sampled.
//   Reset overrides simultaneous we.
// TESTING
//  1 Reset: hold reset 2 cycles mid-PWM -> ch_out=4'hF, rdata=0, COUNT reads 0.
//  2 gen=1, PRESC=0, CH0 duty=64 mode=10 -> ch_out[0]=0 for exactly 64 of every 256 cycles;
//    other channels stay 1.
//  3 CH1 duty=0 mode=10 -> never active; CH1 mode=01 -> ch_out[1]=0 continuously from next cycle.
//  4 Duty 64->192 written at pwm_cnt=100 -> active count 64 for current period, 192 from next period.
//  5 PRESC=3, CH2 duty=128 mode=11 -> pwm_cnt steps every 4 cycles; ch_out[2] active 512 cycles,
//    then silent for the whole next 1024-cycle period, alternating.
//  6 Bus: write CH3=0x0002_00AA, read back 0x0002_00AA next cycle;
//    read 0x80 -> 0; write COUNT ignored; we+re on CH3 returns old value.

Source files
------------

// File: rtl/mmio_pwm_led_ctrl.sv
// Memory-mapped N-channel LED driver: global enable, prescaled PWM counter and
// per-channel off/on/dim/blink modes with duty reloaded glitch-free at period wrap.
module mmio_pwm_led_ctrl #(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_WIDTH  = 8,
  parameter int          PRE_WIDTH  = 16,
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              we,
  input  logic              re,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] ch_out
);

  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_DIM   = 2'b10;
  localparam logic [1:0] MODE_BLINK = 2'b11;

  localparam logic [5:0] IDX_GCTRL = 6'd0;
  localparam logic [5:0] IDX_PRESC = 6'd1;
  localparam logic [5:0] IDX_COUNT = 6'd2;
  localparam logic [5:0] IDX_CH0   = 6'd4;

  logic                 hit;
  logic [5:0]           widx;
  logic                 gen_reg;
  logic [PRE_WIDTH-1:0] presc_reg;
  logic [PRE_WIDTH-1:0] pre_cnt_reg;
  logic [CNT_WIDTH-1:0] pwm_cnt_reg;
  logic                 blink_ph_reg;
  logic                 tick;
  logic                 wrap;
  logic [NUM_CH-1:0]    on_vec;
  logic [NUM_CH-1:0]    ch_out_reg;
  logic [31:0]          rdata_reg;
  logic [31:0]          read_val;
  logic [31:0]          ch_rdata [NUM_CH];
  logic                 unused_bits;

  assign hit  = (addr[31:8] == BASE_ADDR[31:8]);
  assign widx = addr[7:2];
  assign unused_bits = ^{addr[1:0], wdata};

  always_ff @(posedge clk) begin
    if (reset) begin
      gen_reg   <= 1'b0;
      presc_reg <= '0;
    end else if (we && hit) begin
      if (widx == IDX_GCTRL) gen_reg <= wdata[0];
      if (widx == IDX_PRESC) presc_reg <= wdata[PRE_WIDTH-1:0];
    end
  end

  // >= rather than == so a PRESC shrunk below the running count wraps immediately
  assign tick = gen_reg && (pre_cnt_reg >= presc_reg);
  assign wrap = tick && (&pwm_cnt_reg);

  always_ff @(posedge clk) begin
    if (reset || !gen_reg) begin
      pre_cnt_reg  <= '0;
      pwm_cnt_reg  <= '0;
      blink_ph_reg <= 1'b0;
    end else if (tick) begin
      pre_cnt_reg <= '0;
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
      if (wrap) blink_ph_reg <= ~blink_ph_reg;
    end else begin
      pre_cnt_reg <= pre_cnt_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_WIDTH-1:0] duty_reg;
      logic [CNT_WIDTH-1:0] duty_shadow_reg;
      logic [1:0]           mode_reg;
      logic                 ch_wr;
      logic                 below;
      logic [31:0]          rd;

      assign ch_wr = we && hit && (widx == IDX_CH0 + 6'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          duty_reg <= '0;
          mode_reg <= 2'b00;
        end else if (ch_wr) begin
          duty_reg <= wdata[CNT_WIDTH-1:0];
          mode_reg <= wdata[17:16];
        end
      end

      // Shadow follows the register while idle so enabling starts with the current duty
      always_ff @(posedge clk) begin
        if (reset) begin
          duty_shadow_reg <= '0;
        end else if (!gen_reg || wrap) begin
          duty_shadow_reg <= duty_reg;
        end
      end

      assign below = (pwm_cnt_reg < duty_shadow_reg);
      assign on_vec[gi] = (mode_reg == MODE_ON) ||
                          ((mode_reg == MODE_DIM) && below) ||
                          ((mode_reg == MODE_BLINK) && blink_ph_reg && below);

      always_comb begin
        rd = '0;
        rd[17:16] = mode_reg;
        rd[CNT_WIDTH-1:0] = duty_reg;
      end
      assign ch_rdata[gi] = rd;
    end
  endgenerate

  always_comb begin
    read_val = '0;
    if (hit) begin
      case (widx)
        IDX_GCTRL: read_val[0] = gen_reg;
        IDX_PRESC: read_val[PRE_WIDTH-1:0] = presc_reg;
        IDX_COUNT: read_val[CNT_WIDTH-1:0] = pwm_cnt_reg;
        default:   read_val = '0;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
        if (widx == IDX_CH0 + 6'(i)) read_val = ch_rdata[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_out_reg <= {NUM_CH{ACTIVE_LOW}};
      rdata_reg  <= '0;
    end else begin
      ch_out_reg <= (on_vec & {NUM_CH{gen_reg}}) ^ {NUM_CH{ACTIVE_LOW}};
      if (re) rdata_reg <= read_val;
    end
  end

  assign ch_out = ch_out_reg;
  assign rdata  = rdata_reg;

endmodule

// File: tb/tb_mmio_pwm_led_ctrl.sv
// Directed bench for mmio_pwm_led_ctrl: PWM duty/blink timing, duty reload at wrap,
// reset behaviour and a table of bus transactions with hand-computed read data.
module tb_mmio_pwm_led_ctrl;

  localparam logic [31:0] BASE  = 32'hFFFF_FF00;
  localparam logic [31:0] GCTRL = BASE + 32'h00;
  localparam logic [31:0] PRESC = BASE + 32'h04;
  localparam logic [31:0] COUNT = BASE + 32'h08;
  localparam logic [31:0] CH0   = BASE + 32'h10;
  localparam logic [31:0] CH1   = BASE + 32'h14;
  localparam logic [31:0] CH2   = BASE + 32'h18;
  localparam logic [31:0] CH3   = BASE + 32'h1C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic [3:0]  ch_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [17];

  always #5 clk = ~clk;

  mmio_pwm_led_ctrl #(
    .NUM_CH(4), .CNT_WIDTH(8), .PRE_WIDTH(16), .BASE_ADDR(32'hFFFF_FF00), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .we(we), .re(re), .rdata(rdata), .ch_out(ch_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; re = 1'b1;
    step();
    re = 1'b0;
    d = rdata;
  endtask

  task automatic count_active(input int ch, input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      step();
      if (ch_out[ch] === 1'b0) cnt++;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] ra;
    logic [7:0]  dly;
    int          cnt0;
    int          oth;
    int          errs;

    vecs[0]  = '{1'b1, 1'b0, GCTRL, 32'h0000_0000, 32'h0, "gen_off"};
    vecs[1]  = '{1'b1, 1'b0, CH3, 32'h0002_00AA, 32'h0, "wr_ch3"};
    vecs[2]  = '{1'b0, 1'b1, CH3, 32'h0, 32'h0002_00AA, "rd_ch3"};
    vecs[3]  = '{1'b0, 1'b1, BASE + 32'h80, 32'h0, 32'h0, "rd_unmapped_80"};
    vecs[4]  = '{1'b1, 1'b0, COUNT, 32'h0000_0055, 32'h0, "wr_count"};
    vecs[5]  = '{1'b0, 1'b1, COUNT, 32'h0, 32'h0, "rd_count_ro"};
    vecs[6]  = '{1'b1, 1'b1, CH3, 32'h0001_0033, 32'h0002_00AA, "we_re_old"};
    vecs[7]  = '{1'b0, 1'b1, CH3, 32'h0, 32'h0001_0033, "rd_ch3_new"};
    vecs[8]  = '{1'b1, 1'b0, CH3, 32'hFFFF_FFFF, 32'h0, "wr_ch3_ones"};
    vecs[9]  = '{1'b0, 1'b1, BASE + 32'h1F, 32'h0, 32'h0003_00FF, "rd_ch3_unused"};
    vecs[10] = '{1'b1, 1'b0, CH3 ^ 32'h0000_0100, 32'h0000_0012, 32'h0, "wr_outside"};
    vecs[11] = '{1'b0, 1'b1, CH3, 32'h0, 32'h0003_00FF, "rd_ch3_kept"};
    vecs[12] = '{1'b1, 1'b0, PRESC, 32'h0001_2345, 32'h0, "wr_presc"};
    vecs[13] = '{1'b0, 1'b1, PRESC, 32'h0, 32'h0000_2345, "rd_presc"};
    vecs[14] = '{1'b0, 1'b1, BASE + 32'h0C, 32'h0, 32'h0, "rd_unmapped_0c"};
    vecs[15] = '{1'b0, 1'b1, BASE + 32'h20, 32'h0, 32'h0, "rd_ch_beyond"};
    vecs[16] = '{1'b0, 1'b1, GCTRL, 32'h0, 32'h0, "rd_gctrl"};

    reset = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
    step(); step();
    reset = 1'b0;
    check("init_ch_out", {28'h0, ch_out}, 32'h0000_000F);
    check("init_rdata", rdata, 32'h0);

    // Dim at duty 64 on channel 0
    bus_write(CH0, 32'h0002_0040);
    bus_write(GCTRL, 32'h1);
    repeat (3) step();
    for (int w = 0; w < 2; w++) begin
      cnt0 = 0; oth = 0;
      repeat (256) begin
        step();
        if (ch_out[0] === 1'b0) cnt0++;
        if (ch_out[3:1] !== 3'b111) oth++;
      end
      check("dim64_active", cnt0, 64);
      check("dim64_others_idle", oth, 0);
      $display("window %0d: ch0 active=%0d others_bad=%0d", w, cnt0, oth);
    end

    // Duty 0 never active; mode 01 forces on from the cycle after the write lands
    bus_write(CH1, 32'h0002_0000);
    step();
    count_active(1, 256, cnt0);
    check("duty0_active", cnt0, 0);
    bus_write(CH1, 32'h0001_0000);
    check("on_not_yet", {31'h0, ch_out[1]}, 32'h1);
    errs = 0;
    repeat (20) begin
      step();
      if (ch_out[1] !== 1'b0) errs++;
    end
    check("on_continuous", errs, 0);

    // Duty 64 -> 192 written while pwm_cnt is 100
    bus_read(COUNT, rd);
    dly = 8'd99 - rd[7:0];
    repeat (int'(dly)) step();
    bus_write(CH0, 32'h0002_00C0);
    count_active(0, 155, cnt0);
    check("duty_old_rest", cnt0, 0);
    count_active(0, 256, cnt0);
    check("duty_new_p1", cnt0, 192);
    count_active(0, 256, cnt0);
    check("duty_new_p2", cnt0, 192);

    // Blink with prescaler 3
    bus_write(GCTRL, 32'h0);
    step();
    check("gen_off_inactive", {28'h0, ch_out}, 32'h0000_000F);
    bus_write(PRESC, 32'h3);
    bus_write(CH2, 32'h0003_0080);
    bus_write(GCTRL, 32'h1);
    count_active(2, 1024, cnt0);
    check("blink_ph0", cnt0, 0);
    count_active(2, 1024, cnt0);
    check("blink_ph1", cnt0, 512);
    count_active(2, 1024, cnt0);
    check("blink_ph0_again", cnt0, 0);
    bus_read(COUNT, ra);
    repeat (3) step();
    bus_read(COUNT, rd);
    check("presc_step", (rd - ra) & 32'hFF, 32'h1);

    // Reset mid-PWM with a simultaneous write
    reset = 1'b1; addr = CH3; wdata = 32'h0001_0011; we = 1'b1;
    step();
    check("rst1_ch_out", {28'h0, ch_out}, 32'h0000_000F);
    check("rst1_rdata", rdata, 32'h0);
    step();
    reset = 1'b0; we = 1'b0;
    check("rst2_ch_out", {28'h0, ch_out}, 32'h0000_000F);
    bus_read(COUNT, rd);
    check("rst_count", rd, 32'h0);
    bus_read(CH3, rd);
    check("rst_beats_we", rd, 32'h0);
    bus_read(PRESC, rd);
    check("rst_presc", rd, 32'h0);
    bus_read(CH2, rd);
    check("rst_ch2", rd, 32'h0);

    // Bus transaction table
    for (int i = 0; i < 17; i++) begin
      addr = vecs[i].addr; wdata = vecs[i].wdata; we = vecs[i].we; re = vecs[i].re;
      step();
      we = 1'b0; re = 1'b0;
      $display("txn %0d %s we=%0b re=%0b addr=%h wdata=%h rdata=%h",
               i, vecs[i].name, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, rdata);
      if (vecs[i].re) check(vecs[i].name, rdata, vecs[i].exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
